// File: rtl/bram_xyz_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_xyz_port_arbiter
//
// Purpose:
//   Shares the single port of the x/y/z point-cloud BRAMs between three
//   requesters: core-cache loader (0), distance-feeder streamer (1) and
//   outlier write-back (2). One access is issued per cycle. Fixed priority
//   is 0 > 1 > 2, but a requester that has waited STARVE_LIMIT cycles
//   overrides fixed priority. Read data is returned tagged with the id of
//   the requester that issued the read.
//
// Ports:
//   i_clock                 system clock, rising edge
//   i_reset                 asynchronous reset, active low
//   i_hold                  1 = issue no grants
//   i_req[2:0]              per-requester access request, held until granted
//   i_wr[2:0]               per-requester 1=write, 0=read
//   i_addr[95:0]            per-requester byte address, slice i = [32*i +: 32]
//   i_wdata[9*BUS_SIZE-1:0] per-requester {z,y,x} write data
//   o_grant[2:0]            combinational grant, transfer when req & grant
//   o_rvalid[2:0]           read data valid for requester i (one-hot or 0)
//   o_rdata_x/y/z           BRAM read data passed through
//   o_bram_addr/en/we       registered address/enable/byte-write-enable
//   o_write_in_x/y/z        registered write data
//   i_read_out_x/y/z        BRAM read data
//   o_busy                  1 while any read is in flight
// ---------------------------------------------------------------------------
module bram_xyz_port_arbiter #(
    parameter int BUS_SIZE     = 32,
    parameter int BRAM_SHIFT   = 2,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_hold,
    input  logic [2:0]              i_req,
    input  logic [2:0]              i_wr,
    input  logic [95:0]             i_addr,
    input  logic [9*BUS_SIZE-1:0]   i_wdata,
    output logic [2:0]              o_grant,
    output logic [2:0]              o_rvalid,
    output logic [BUS_SIZE-1:0]     o_rdata_x,
    output logic [BUS_SIZE-1:0]     o_rdata_y,
    output logic [BUS_SIZE-1:0]     o_rdata_z,
    output logic [31:0]             o_bram_addr,
    output logic                    o_bram_en,
    output logic [3:0]              o_bram_we,
    output logic [BUS_SIZE-1:0]     o_write_in_x,
    output logic [BUS_SIZE-1:0]     o_write_in_y,
    output logic [BUS_SIZE-1:0]     o_write_in_z,
    input  logic [BUS_SIZE-1:0]     i_read_out_x,
    input  logic [BUS_SIZE-1:0]     i_read_out_y,
    input  logic [BUS_SIZE-1:0]     i_read_out_z,
    output logic                    o_busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Parameter sanity checks at elaboration time. Addresses arrive already
    // shifted by BRAM_SHIFT, so the shift only needs to be a legal amount.
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_badLatency
            $error("READ_LATENCY must be in 1..4");
        end
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_badStarve
            $error("STARVE_LIMIT must be in 1..15");
        end
        if (BRAM_SHIFT < 0 || BRAM_SHIFT > 31) begin : g_badShift
            $error("BRAM_SHIFT must be in 0..31");
        end
    endgenerate

    logic [2:0][3:0]                r_waitCnt;
    logic [READ_LATENCY:0]          r_tagValid;
    logic [READ_LATENCY:0][1:0]     r_tagId;

    logic [2:0]                     w_starved;
    logic [2:0]                     w_grant;
    logic [1:0]                     w_winner;
    logic                           w_anyWin;
    logic [31:0]                    w_selAddr;
    logic [BUS_SIZE-1:0]            w_selX;
    logic [BUS_SIZE-1:0]            w_selY;
    logic [BUS_SIZE-1:0]            w_selZ;
    logic                           w_selWr;

    // Starved requesters beat fixed priority; among several starved (or
    // several plain) requesters the lowest index wins. Grant is also forced
    // low while reset is asserted, independent of the clock.
    always_comb begin
        w_grant   = '0;
        w_winner  = '0;
        w_anyWin  = 1'b0;
        w_starved = '0;
        for (int i = 0; i < 3; i++) begin
            w_starved[i] = i_req[i] && (r_waitCnt[i] == LIMIT);
        end
        if (i_reset && !i_hold) begin
            if (|w_starved) begin
                w_anyWin = 1'b1;
                for (int i = 2; i >= 0; i--) begin
                    if (w_starved[i]) w_winner = 2'(i);
                end
            end else if (|i_req) begin
                w_anyWin = 1'b1;
                for (int i = 2; i >= 0; i--) begin
                    if (i_req[i]) w_winner = 2'(i);
                end
            end
        end
        if (w_anyWin) w_grant[w_winner] = 1'b1;
    end

    // Mux the winner's address, write flag and {z,y,x} data.
    always_comb begin
        w_selAddr = '0;
        w_selX    = '0;
        w_selY    = '0;
        w_selZ    = '0;
        w_selWr   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (w_winner == 2'(i)) begin
                w_selAddr = i_addr[32*i +: 32];
                w_selX    = i_wdata[3*BUS_SIZE*i +: BUS_SIZE];
                w_selY    = i_wdata[3*BUS_SIZE*i + BUS_SIZE +: BUS_SIZE];
                w_selZ    = i_wdata[3*BUS_SIZE*i + 2*BUS_SIZE +: BUS_SIZE];
                w_selWr   = i_wr[i];
            end
        end
    end

    // Issue register. Write data only updates on writes so the BRAM data
    // lines stay quiet during reads; the address holds when idle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_bram_addr  <= '0;
            o_bram_en    <= 1'b0;
            o_bram_we    <= '0;
            o_write_in_x <= '0;
            o_write_in_y <= '0;
            o_write_in_z <= '0;
        end else if (w_anyWin) begin
            o_bram_addr <= w_selAddr;
            o_bram_en   <= 1'b1;
            o_bram_we   <= w_selWr ? 4'hF : 4'h0;
            if (w_selWr) begin
                o_write_in_x <= w_selX;
                o_write_in_y <= w_selY;
                o_write_in_z <= w_selZ;
            end
        end else begin
            o_bram_en <= 1'b0;
            o_bram_we <= '0;
        end
    end

    // Wait counters age pending requests; hold freezes them so a pause
    // does not turn every requester into a starved one.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_waitCnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!i_req[i] || w_grant[i]) begin
                    r_waitCnt[i] <= '0;
                end else if (!i_hold && (r_waitCnt[i] < LIMIT)) begin
                    r_waitCnt[i] <= r_waitCnt[i] + 4'd1;
                end
            end
        end
    end

    // Read tag pipeline: READ_LATENCY+1 stages, one for the address register
    // plus one per BRAM cycle, so the last stage lines up with read_out.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tagValid <= '0;
            r_tagId    <= '0;
        end else begin
            r_tagValid <= {r_tagValid[READ_LATENCY-1:0], (w_anyWin && !w_selWr)};
            r_tagId    <= {r_tagId[READ_LATENCY-1:0], w_winner};
        end
    end

    always_comb begin
        o_rvalid = '0;
        if (r_tagValid[READ_LATENCY]) o_rvalid[r_tagId[READ_LATENCY]] = 1'b1;
    end

    assign o_grant   = w_grant;
    assign o_busy    = |r_tagValid;
    assign o_rdata_x = i_read_out_x;
    assign o_rdata_y = i_read_out_y;
    assign o_rdata_z = i_read_out_z;

endmodule

// File: tb/tb_bram_xyz_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_xyz_port_arbiter
//
// Directed bench for bram_xyz_port_arbiter. Instance dut uses
// READ_LATENCY=1, instance dut2 uses READ_LATENCY=2; both share inputs.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge, so "cycle n" is the window between rising edges n, n+1.
// ---------------------------------------------------------------------------
module tb_bram_xyz_port_arbiter;

    localparam int BUS = 32;

    logic             clk;
    logic             rstN;
    logic             hold;
    logic [2:0]       req;
    logic [2:0]       wr;
    logic [95:0]      addr;
    logic [9*BUS-1:0] wdata;
    logic [BUS-1:0]   readX, readY, readZ;

    logic [2:0]       grant, rvalid;
    logic [BUS-1:0]   rdataX, rdataY, rdataZ;
    logic [31:0]      bramAddr;
    logic             bramEn;
    logic [3:0]       bramWe;
    logic [BUS-1:0]   writeX, writeY, writeZ;
    logic             busy;

    logic [2:0]       grant2, rvalid2;
    logic [BUS-1:0]   rdataX2, rdataY2, rdataZ2;
    logic [31:0]      bramAddr2;
    logic             bramEn2;
    logic [3:0]       bramWe2;
    logic [BUS-1:0]   writeX2, writeY2, writeZ2;
    logic             busy2;

    int errorCount = 0;
    int checkCount = 0;

    bram_xyz_port_arbiter #(.BUS_SIZE(BUS), .BRAM_SHIFT(2), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .i_clock(clk), .i_reset(rstN), .i_hold(hold), .i_req(req), .i_wr(wr),
        .i_addr(addr), .i_wdata(wdata), .o_grant(grant), .o_rvalid(rvalid),
        .o_rdata_x(rdataX), .o_rdata_y(rdataY), .o_rdata_z(rdataZ),
        .o_bram_addr(bramAddr), .o_bram_en(bramEn), .o_bram_we(bramWe),
        .o_write_in_x(writeX), .o_write_in_y(writeY), .o_write_in_z(writeZ),
        .i_read_out_x(readX), .i_read_out_y(readY), .i_read_out_z(readZ),
        .o_busy(busy)
    );

    bram_xyz_port_arbiter #(.BUS_SIZE(BUS), .BRAM_SHIFT(2), .READ_LATENCY(2), .STARVE_LIMIT(4)) dut2 (
        .i_clock(clk), .i_reset(rstN), .i_hold(hold), .i_req(req), .i_wr(wr),
        .i_addr(addr), .i_wdata(wdata), .o_grant(grant2), .o_rvalid(rvalid2),
        .o_rdata_x(rdataX2), .o_rdata_y(rdataY2), .o_rdata_z(rdataZ2),
        .o_bram_addr(bramAddr2), .o_bram_en(bramEn2), .o_bram_we(bramWe2),
        .o_write_in_x(writeX2), .o_write_in_y(writeY2), .o_write_in_z(writeZ2),
        .i_read_out_x(readX), .i_read_out_y(readY), .i_read_out_z(readZ),
        .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic [2:0] r, input logic [2:0] w);
        hold = h;
        req  = r;
        wr   = w;
    endtask

    task automatic setRequester(input int id, input logic [31:0] a,
                                input logic [BUS-1:0] x, input logic [BUS-1:0] y, input logic [BUS-1:0] z);
        addr[32*id +: 32]        = a;
        wdata[3*BUS*id +: 3*BUS] = {z, y, x};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [2:0] starveExp [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};

    initial begin
        rstN  = 1'b0;
        hold  = 1'b0;
        req   = 3'b111;
        wr    = 3'b000;
        addr  = '0;
        wdata = '0;
        readX = 32'hDEADBEEF;
        readY = 32'h01234567;
        readZ = 32'h89ABCDEF;

        // Reset values, grant forced low despite requests
        sample();
        checkOutput("rst_grant", 64'(grant), 64'(3'b000));
        checkOutput("rst_en", 64'(bramEn), 64'(1'b0));
        checkOutput("rst_addr", 64'(bramAddr), 64'h0);
        checkOutput("rst_we", 64'(bramWe), 64'h0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_wx", 64'(writeX), 64'h0);

        nextCycle();
        rstN = 1'b1;
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("idle_grant", 64'(grant), 64'h0);

        // Single read by requester 1, READ_LATENCY=1
        nextCycle();
        setRequester(1, 32'h10, '0, '0, '0);
        applyStimulus(1'b0, 3'b010, 3'b000);
        sample();
        checkOutput("t1_grant", 64'(grant), 64'(3'b010));
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t1_addr", 64'(bramAddr), 64'h10);
        checkOutput("t1_en", 64'(bramEn), 64'h1);
        checkOutput("t1_we", 64'(bramWe), 64'h0);
        checkOutput("t1_busy_c1", 64'(busy), 64'h1);
        checkOutput("t1_rvalid_c1", 64'(rvalid), 64'h0);
        nextCycle();
        sample();
        checkOutput("t1_rvalid_c2", 64'(rvalid), 64'(3'b010));
        checkOutput("t1_rdata_x", 64'(rdataX), 64'hDEADBEEF);
        checkOutput("t1_busy_c2", 64'(busy), 64'h1);
        checkOutput("t1_en_c2", 64'(bramEn), 64'h0);
        nextCycle();
        sample();
        checkOutput("t1_rvalid_c3", 64'(rvalid), 64'h0);
        checkOutput("t1_busy_c3", 64'(busy), 64'h0);

        // Starvation: req0 and req2 held continuously
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            applyStimulus(1'b0, 3'b101, 3'b000);
            sample();
            checkOutput($sformatf("t2_grant_c%0d", c), 64'(grant), 64'(starveExp[c]));
        end
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        repeat (4) nextCycle();

        // Write with nonzero data by requester 2
        setRequester(2, 32'h40, 32'h11111111, 32'h22222222, 32'h33333333);
        applyStimulus(1'b0, 3'b100, 3'b100);
        sample();
        checkOutput("t3a_grant", 64'(grant), 64'(3'b100));
        nextCycle();
        setRequester(0, 32'h4, '0, '0, '0);
        applyStimulus(1'b0, 3'b001, 3'b000);
        sample();
        checkOutput("t3a_we", 64'(bramWe), 64'hF);
        checkOutput("t3a_wx", 64'(writeX), 64'h11111111);
        checkOutput("t3a_wy", 64'(writeY), 64'h22222222);
        checkOutput("t3a_wz", 64'(writeZ), 64'h33333333);
        checkOutput("t3a_busy", 64'(busy), 64'h0);
        // The read by requester 0 must leave write data untouched
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t3b_we", 64'(bramWe), 64'h0);
        checkOutput("t3b_addr", 64'(bramAddr), 64'h4);
        checkOutput("t3b_wx_kept", 64'(writeX), 64'h11111111);
        checkOutput("t3b_wz_kept", 64'(writeZ), 64'h33333333);
        repeat (3) nextCycle();

        // Zero write by requester 2
        setRequester(2, 32'h8, '0, '0, '0);
        applyStimulus(1'b0, 3'b100, 3'b100);
        sample();
        checkOutput("t3c_grant", 64'(grant), 64'(3'b100));
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t3c_we", 64'(bramWe), 64'hF);
        checkOutput("t3c_addr", 64'(bramAddr), 64'h8);
        checkOutput("t3c_wx", 64'(writeX), 64'h0);
        checkOutput("t3c_wy", 64'(writeY), 64'h0);
        checkOutput("t3c_rvalid", 64'(rvalid), 64'h0);
        nextCycle();
        sample();
        checkOutput("t3c_rvalid_c2", 64'(rvalid), 64'h0);
        checkOutput("t3c_busy", 64'(busy), 64'h0);

        // Hold with req1 pending for 6 cycles
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            setRequester(1, 32'h30, '0, '0, '0);
            applyStimulus(1'b1, 3'b010, 3'b000);
            sample();
            checkOutput($sformatf("t4_grant_c%0d", c), 64'(grant), 64'h0);
            checkOutput($sformatf("t4_en_c%0d", c), 64'(bramEn), 64'h0);
        end
        checkOutput("t4_wait1", 64'(dut.r_waitCnt[1]), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 3'b010, 3'b000);
        sample();
        checkOutput("t4_release_grant", 64'(grant), 64'(3'b010));
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t4_addr", 64'(bramAddr), 64'h30);
        repeat (3) nextCycle();

        // Simultaneous req0 and req1, no starvation
        setRequester(0, 32'h50, '0, '0, '0);
        setRequester(1, 32'h54, '0, '0, '0);
        applyStimulus(1'b0, 3'b011, 3'b000);
        sample();
        checkOutput("t6_grant_c0", 64'(grant), 64'(3'b001));
        nextCycle();
        applyStimulus(1'b0, 3'b010, 3'b000);
        sample();
        checkOutput("t6_grant_c1", 64'(grant), 64'(3'b010));
        checkOutput("t6_addr_c1", 64'(bramAddr), 64'h50);
        checkOutput("t6_rvalid_c1", 64'(rvalid), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t6_addr_c2", 64'(bramAddr), 64'h54);
        checkOutput("t6_rvalid_c2", 64'(rvalid), 64'(3'b001));
        nextCycle();
        sample();
        checkOutput("t6_rvalid_c3", 64'(rvalid), 64'(3'b010));
        repeat (3) nextCycle();

        // READ_LATENCY=2: back-to-back reads, in-order return
        setRequester(0, 32'h20, '0, '0, '0);
        setRequester(1, 32'h24, '0, '0, '0);
        applyStimulus(1'b0, 3'b001, 3'b000);
        sample();
        checkOutput("t5a_grant_c0", 64'(grant2), 64'(3'b001));
        nextCycle();
        applyStimulus(1'b0, 3'b010, 3'b000);
        sample();
        checkOutput("t5a_grant_c1", 64'(grant2), 64'(3'b010));
        nextCycle();
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t5a_rvalid_c2", 64'(rvalid2), 64'h0);
        checkOutput("t5a_busy_c2", 64'(busy2), 64'h1);
        nextCycle();
        sample();
        checkOutput("t5a_rvalid_c3", 64'(rvalid2), 64'(3'b001));
        nextCycle();
        sample();
        checkOutput("t5a_rvalid_c4", 64'(rvalid2), 64'(3'b010));
        nextCycle();
        sample();
        checkOutput("t5a_rvalid_c5", 64'(rvalid2), 64'h0);
        checkOutput("t5a_busy_c5", 64'(busy2), 64'h0);
        repeat (2) nextCycle();

        // Same reads, reset asserted in cycle 2 discards them
        applyStimulus(1'b0, 3'b001, 3'b000);
        nextCycle();
        applyStimulus(1'b0, 3'b010, 3'b000);
        nextCycle();
        rstN = 1'b0;
        applyStimulus(1'b0, 3'b001, 3'b000);
        sample();
        checkOutput("t5b_grant_rst", 64'(grant2), 64'h0);
        checkOutput("t5b_busy_rst", 64'(busy2), 64'h0);
        checkOutput("t5b_en_rst", 64'(bramEn2), 64'h0);
        checkOutput("t5b_addr_rst", 64'(bramAddr2), 64'h0);
        nextCycle();
        rstN = 1'b1;
        applyStimulus(1'b0, 3'b000, 3'b000);
        sample();
        checkOutput("t5b_rvalid_c3", 64'(rvalid2), 64'h0);
        checkOutput("t5b_busy_c3", 64'(busy2), 64'h0);
        nextCycle();
        sample();
        checkOutput("t5b_rvalid_c4", 64'(rvalid2), 64'h0);
        nextCycle();
        sample();
        checkOutput("t5b_rvalid_c5", 64'(rvalid2), 64'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
